uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter. It is the transmit-side counterpart to the uart_recv receive path.
- Accepts bytes from fabric logic over a valid/ready handshake and holds them in an internal FIFO.
- Serializes bytes onto uart_txd back-to-back with no idle gap.
- Replaces the unbuffered uart_send plus busy-polling wherever a producer emits bursts, e.g. status or debug dumps.

Parameters:
- CLK_FREQ, 200_000_000: clk frequency in Hz.
- UART_BPS, 115200: baud rate. BPS_CNT = CLK_FREQ/UART_BPS, integer-truncated, which gives 1736 at the defaults.
- FIFO_DEPTH, 16: FIFO entries. Power of 2, minimum 2.

Ports:
- clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous reset, active-high.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a byte. Combinational: !full && !sys_rst.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy (registered).
- tx_busy  out  1  serializer is not IDLE.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- uart_txd  out  1  serial output, idles high. Registered.

Behaviour:
- Reset, sampled on rising clk while sys_rst=1:
  - uart_txd=1, tx_busy=0, tx_done=0.
  - FIFO pointers and fifo_level=0, state=IDLE, bit counter=0.
  - Reset mid-frame aborts the frame; uart_txd=1 from the next edge.
  - Queued bytes are discarded.
- Write: occurs when tx_valid && tx_ready at a clk edge. tx_data must hold until accepted.
  - When full, tx_ready=0 and there is no write.
  - When full and a pop happens in the same cycle, tx_ready still reads 0 that cycle, so no write occurs.
- Pop/write timing:
  - A simultaneous pop and write on a non-full, non-empty FIFO leaves the level unchanged.
  - No bypass path: a byte written into an empty FIFO is visible to the serializer on the next cycle.
- State machine IDLE -> START -> DATA -> STOP:
  - Each state or bit lasts exactly BPS_CNT cycles, timed by a baud counter running 0..BPS_CNT-1.
  - IDLE: uart_txd=1. If fifo_level!=0: pop into an 8-bit shift register, go to START.
  - START: uart_txd=0.
  - DATA: 8 bits, LSB first, uart_txd=shift[0]. Shift right at each bit boundary.
  - STOP: uart_txd=1. On the last stop cycle, tx_done=1.
    - If the FIFO is non-empty on that cycle: pop and go directly to START, so the next start bit immediately follows the stop bit.
    - Otherwise go to IDLE.
- Latency: byte accepted at edge N into an idle, empty block -> pop at edge N+1 -> uart_txd=0 from edge N+2.
- Frame length: 10*BPS_CNT cycles. Sustained throughput is one byte per 10*BPS_CNT cycles.
- tx_busy=1 in START, DATA and STOP (plus the PARITY state when UART_TX_PARITY_EN is defined). It drops to 0 only on entering IDLE.
- fifo_level wraps correctly:
  - Pointers are $clog2(FIFO_DEPTH) bits.
  - Full means level==FIFO_DEPTH; empty means level==0.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP, lasting BPS_CNT cycles.
  - uart_txd = XOR of the 8 data bits (even parity).
  - Frame becomes 11*BPS_CNT cycles.
- Not defined: no parity state; 8N1 only.

Test Plan:
- Use CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10) and FIFO_DEPTH=4 unless noted.
- Single byte 0x55 written at cycle N:
  - uart_txd falls at N+2.
  - Sampled mid-bit: 0,1,0,1,0,1,0,1,0,1.
  - tx_done pulses once at N+101; tx_busy is 0 from N+102.
- Back-to-back 0xA5, 0x3C written on consecutive cycles:
  - Second start bit begins exactly 100 cycles after the first.
  - No idle-high cycle between the frames.
- Hold tx_valid for 8 bytes (0x00..0x07):
  - 5 accepted (1 popped + 4 queued), then tx_ready=0 and fifo_level=4.
  - tx_ready returns to 1 each time a pop occurs.
  - All 8 bytes appear on the line in order, with no loss or duplication.
- sys_rst=1 for 1 cycle during bit 3 of 0xFF with 2 bytes queued:
  - uart_txd=1 next cycle; fifo_level=0; tx_busy=0.
  - No further frames.
- With UART_TX_PARITY_EN, send 0x07:
  - Parity bit=1.
  - Frame is 110 cycles.
  - tx_done pulses at the end of the stop bit.
- With defaults (200 MHz / 115200), send 0x0F: each bit lasts exactly 1736 cycles.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter. Bytes arrive from fabric logic over a
// valid/ready handshake and wait in a small FIFO. The serializer drains the
// FIFO onto uart_txd back-to-back, with no idle gap between frames.
//
// Parameters:
//   CLK_FREQ    clk frequency in Hz
//   UART_BPS    baud rate; one bit lasts CLK_FREQ/UART_BPS clk cycles
//   FIFO_DEPTH  FIFO entries, power of 2, at least 2
//
// Ports:
//   clk         system clock, the only clock
//   sys_rst     synchronous active-high reset
//   tx_data     byte to transmit, held until accepted
//   tx_valid    tx_data is valid
//   tx_ready    FIFO can take a byte (combinational: not full, not in reset)
//   fifo_level  registered FIFO occupancy
//   tx_busy     serializer is in the middle of a frame
//   tx_done     one-cycle pulse in the last cycle of each stop bit
//   uart_txd    registered serial output, idles high
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (11-bit frames).
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
   parameter int CLK_FREQ   = 200_000_000,
   parameter int UART_BPS   = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          sys_rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic                          uart_txd
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [7:0]       head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             wr_en;
   logic             pop;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic             baud_last;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   // FIFO status and handshake. tx_ready deliberately ignores a pop in the
   // same cycle, so a full FIFO never accepts a byte even while draining.
   assign fifo_full  = (fifo_level == LVL_FULL);
   assign fifo_empty = (fifo_level == '0);
   assign tx_ready   = !fifo_full && !sys_rst;
   assign wr_en      = tx_valid && tx_ready;
   assign head       = mem[rd_ptr];
   assign baud_last  = (baud_cnt == CNT_LAST);

   // The serializer takes a byte either when idle or on the final cycle of a
   // stop bit; the latter is what lets frames follow each other with no gap.
   assign pop = !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && baud_last));

   // FIFO storage. Contents need no reset because the level and pointers
   // decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy. Pointers wrap naturally because the depth
   // is a power of 2; the extra level bit tells full apart from empty.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Serializer state machine. The outputs are registered decodes of the
   // current state, so the line, tx_busy and tx_done all trail the state
   // register by one cycle. Every non-idle state lasts BPS_CNT cycles,
   // timed by baud_cnt; data goes out LSB first from a right-shifting
   // register loaded at pop time.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         uart_txd <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_busy <= (state != IDLE);
         tx_done <= (state == STOP) && baud_last;

         case (state)
            START:   uart_txd <= 1'b0;
            DATA:    uart_txd <= shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  uart_txd <= parity_bit;
`endif
            default: uart_txd <= 1'b1;
         endcase

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (!fifo_empty) begin
                  shift <= head;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^head;
`endif
                  state <= START;
               end
            end

            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`endif

            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  if (!fifo_empty) begin
                     shift <= head;
`ifdef UART_TX_PARITY_EN
                     parity_bit <= ^head;
`endif
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

            default: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Self-checking bench for uart_tx_buffered. The main instance runs at
// BPS_CNT=10 with a 4-entry FIFO; a second instance at the default
// 200 MHz / 115200 settings checks bit timing at full scale.
// Expected line behaviour comes from a frame model (start, data LSB first,
// optional even parity, stop) and a queue of accepted bytes; a line decoder
// samples each bit mid-way and compares against that queue.
// Define UART_TX_PARITY_EN for both bench and RTL to check parity frames.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_buffered;

   localparam int CLK_FREQ   = 1_000_000;
   localparam int UART_BPS   = 100_000;
   localparam int FIFO_DEPTH = 4;
   localparam int BPS        = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME  = NBITS * BPS;
   localparam int BPS2   = 200_000_000 / 115200;
   localparam int FRAME2 = NBITS * BPS2;
   localparam int LW     = $clog2(FIFO_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          sys_rst;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [LW-1:0] fifo_level;
   logic          tx_busy;
   logic          tx_done;
   logic          uart_txd;

   logic [7:0]    tx_data2;
   logic          tx_valid2;
   logic          tx_ready2;
   logic [4:0]    fifo_level2;
   logic          tx_busy2;
   logic          tx_done2;
   logic          uart_txd2;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   logic [7:0] exp_q[$];

   uart_tx_buffered #(
      .CLK_FREQ   (CLK_FREQ),
      .UART_BPS   (UART_BPS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fifo_level (fifo_level),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .uart_txd   (uart_txd)
   );

   uart_tx_buffered dut_def (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .tx_data    (tx_data2),
      .tx_valid   (tx_valid2),
      .tx_ready   (tx_ready2),
      .fifo_level (fifo_level2),
      .tx_busy    (tx_busy2),
      .tx_done    (tx_done2),
      .uart_txd   (uart_txd2)
   );

   // 10 ns clock; cyc counts rising edges so "edge N" is readable after it.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so a stuck design still ends the run with a visible failure.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Line level expected for bit k of a frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   // Offers one byte and holds it until accepted; acc_cyc is the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, output int acc_cyc);
      int guard;
      guard = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && guard < 20 * FRAME) begin
         step_cycle();
         guard++;
      end
      if (!tx_ready) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: got tx_ready=%b, expected 1", tx_ready);
         tx_valid = 1'b0;
         acc_cyc  = cyc;
      end else begin
         step_cycle();
         acc_cyc  = cyc;
         tx_valid = 1'b0;
         exp_q.push_back(d);
      end
   endtask

   task automatic mon_wait(input int n, inout logic ab);
      for (int i = 0; i < n && !ab; i++) begin
         @(negedge clk);
         if (sys_rst) ab = 1'b1;
      end
   endtask

   // Line decoder: finds each start bit, samples every bit mid-way and checks
   // the recovered frame against the queue of accepted bytes. A reset seen
   // during a frame abandons it.
   initial begin : line_monitor
      logic prev, ab, start_bit, stop_bit, par_bit;
      logic [7:0] b, e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!sys_rst && prev === 1'b1 && uart_txd === 1'b0) begin
            ab = 1'b0; b = '0; par_bit = 1'b0;
            mon_wait(BPS / 2, ab);
            start_bit = uart_txd;
            for (int i = 0; i < 8; i++) begin
               mon_wait(BPS, ab);
               b[i] = uart_txd;
            end
`ifdef UART_TX_PARITY_EN
            mon_wait(BPS, ab);
            par_bit = uart_txd;
`endif
            mon_wait(BPS, ab);
            stop_bit = uart_txd;
            if (!ab) begin
               vectors++;
               if (start_bit !== 1'b0) begin
                  miscompares++;
                  $display("[TB] FAIL start_bit: got %b, expected 0", start_bit);
               end
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_frame: got %h, expected no frame", b);
               end else begin
                  e = exp_q.pop_front();
                  vectors++;
                  if (b !== e) begin
                     miscompares++;
                     $display("[TB] FAIL frame_data: got %h, expected %h", b, e);
                  end
`ifdef UART_TX_PARITY_EN
                  vectors++;
                  if (par_bit !== ^e) begin
                     miscompares++;
                     $display("[TB] FAIL parity_bit: got %b, expected %b", par_bit, ^e);
                  end
`endif
               end
               vectors++;
               if (stop_bit !== 1'b1) begin
                  miscompares++;
                  $display("[TB] FAIL stop_bit: got %b, expected 1", stop_bit);
               end
            end
         end
         prev = uart_txd;
      end
   end

   task automatic test_reset();
      sys_rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
      tx_valid2 = 1'b0; tx_data2 = '0;
      repeat (3) step_cycle();
      vectors += 7;
      if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_txd: got %b, expected 1", uart_txd); end
      if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b, expected 0", tx_busy); end
      if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done: got %b, expected 0", tx_done); end
      if (fifo_level !== '0) begin miscompares++; $display("[TB] FAIL rst_level: got %0d, expected 0", fifo_level); end
      if (tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready: got %b, expected 0", tx_ready); end
      if (uart_txd2 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_txd2: got %b, expected 1", uart_txd2); end
      if (fifo_level2 !== '0) begin miscompares++; $display("[TB] FAIL rst_level2: got %0d, expected 0", fifo_level2); end
      sys_rst = 1'b0;
      step_cycle();
      vectors += 2;
      if (tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_ready: got %b, expected 1", tx_ready); end
      if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_txd: got %b, expected 1", uart_txd); end
   endtask

   task automatic test_single();
      int n, c;
      logic exp_bit, exp_busy, exp_done;
      applyStimulus(8'h55, n);
      for (int k = 1; k <= FRAME + 3; k++) begin
         step_cycle();
         c = cyc - n;
         if (c == 1) begin
            vectors += 2;
            if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_early: got %b, expected 1", uart_txd); end
            if (fifo_level !== '0) begin miscompares++; $display("[TB] FAIL single_pop: got %0d, expected 0", fifo_level); end
         end
         if (c == 2) begin
            vectors++;
            if (uart_txd !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_start: got %b, expected 0", uart_txd); end
         end
         if (c >= 2 && (c - 2) % BPS == BPS / 2 && (c - 2) / BPS < NBITS) begin
            exp_bit = frame_bit(8'h55, (c - 2) / BPS);
            vectors++;
            if (uart_txd !== exp_bit) begin
               miscompares++;
               $display("[TB] FAIL midbit_%0d: got %b, expected %b", (c - 2) / BPS, uart_txd, exp_bit);
            end
         end
         exp_done = (c == FRAME + 1);
         exp_busy = (c >= 2 && c <= FRAME + 1);
         vectors += 2;
         if (tx_done !== exp_done) begin miscompares++; $display("[TB] FAIL done_c%0d: got %b, expected %b", c, tx_done, exp_done); end
         if (tx_busy !== exp_busy) begin miscompares++; $display("[TB] FAIL busy_c%0d: got %b, expected %b", c, tx_busy, exp_busy); end
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int n, c;
      applyStimulus(8'h07, n);
      for (int k = 1; k <= FRAME + 3; k++) begin
         step_cycle();
         c = cyc - n;
         if (c == 2 + 9 * BPS + BPS / 2) begin
            vectors++;
            if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_07: got %b, expected 1", uart_txd); end
         end
         if (c == 2 + 10 * BPS + BPS / 2) begin
            vectors++;
            if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_stop: got %b, expected 1", uart_txd); end
         end
         vectors++;
         if (tx_done !== (c == FRAME + 1)) begin
            miscompares++;
            $display("[TB] FAIL parity_done_c%0d: got %b, expected %b", c, tx_done, (c == FRAME + 1));
         end
      end
   endtask
`endif

   task automatic test_back_to_back();
      int n1, n2, d, f;
      logic exp_bit, exp_done;
      logic [7:0] bytes [2];
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      applyStimulus(bytes[0], n1);
      applyStimulus(bytes[1], n2);
      vectors++;
      if (n2 !== n1 + 1) begin miscompares++; $display("[TB] FAIL b2b_accept: got %0d, expected %0d", n2, n1 + 1); end
      for (int k = 1; k <= 2 * FRAME + 4; k++) begin
         step_cycle();
         d = cyc - n1;
         if (d >= 2 && d < 2 + 2 * FRAME) begin
            f = (d - 2) / FRAME;
            exp_bit = frame_bit(bytes[f], ((d - 2) % FRAME) / BPS);
         end else begin
            exp_bit = 1'b1;
         end
         exp_done = (d == FRAME + 1) || (d == 2 * FRAME + 1);
         vectors += 2;
         if (uart_txd !== exp_bit) begin miscompares++; $display("[TB] FAIL b2b_line_c%0d: got %b, expected %b", d, uart_txd, exp_bit); end
         if (tx_done !== exp_done) begin miscompares++; $display("[TB] FAIL b2b_done_c%0d: got %b, expected %b", d, tx_done, exp_done); end
      end
   endtask

   task automatic test_hold8();
      int acc [8];
      int next, guard;
      next = 0; guard = 0;
      tx_valid = 1'b1;
      while (next < 8 && guard < 12 * FRAME) begin
         logic rdy;
         tx_data = 8'(next);
         rdy = tx_ready;
         step_cycle();
         guard++;
         if (rdy) begin
            acc[next] = cyc;
            exp_q.push_back(8'(next));
            next++;
            if (next > 5) begin
               vectors++;
               if (fifo_level !== LW'(4)) begin miscompares++; $display("[TB] FAIL hold_refill_level: got %0d, expected 4", fifo_level); end
            end
         end
         if (next >= 1 && cyc == acc[0] + 4) begin
            vectors += 3;
            if (next !== 5) begin miscompares++; $display("[TB] FAIL hold_accepted: got %0d, expected 5", next); end
            if (tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready: got %b, expected 0", tx_ready); end
            if (fifo_level !== LW'(4)) begin miscompares++; $display("[TB] FAIL hold_level: got %0d, expected 4", fifo_level); end
         end
      end
      tx_valid = 1'b0;
      vectors++;
      if (next !== 8) begin miscompares++; $display("[TB] FAIL hold_count: got %0d, expected 8", next); end
      for (int k = 1; k < next; k++) begin
         int want;
         want = (k < 5) ? acc[0] + k : acc[0] + 2 + (k - 4) * FRAME;
         vectors++;
         if (acc[k] !== want) begin miscompares++; $display("[TB] FAIL hold_accept_%0d: got %0d, expected %0d", k, acc[k], want); end
      end
      guard = 0;
      while ((exp_q.size() != 0 || tx_busy) && guard < 10 * FRAME) begin
         step_cycle();
         guard++;
      end
      vectors += 2;
      if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL hold_drain: got %0d left, expected 0", exp_q.size()); end
      if (fifo_level !== '0) begin miscompares++; $display("[TB] FAIL hold_end_level: got %0d, expected 0", fifo_level); end
   endtask

   task automatic test_reset_mid();
      int n, n1, n2, bad;
      applyStimulus(8'hFF, n);
      applyStimulus(8'h11, n1);
      applyStimulus(8'h22, n2);
      while (cyc < n + 2 + 3 * BPS + 3) step_cycle();
      vectors++;
      if (fifo_level !== LW'(2)) begin miscompares++; $display("[TB] FAIL mid_queued: got %0d, expected 2", fifo_level); end
      sys_rst = 1'b1;
      step_cycle();
      sys_rst = 1'b0;
      exp_q.delete();
      vectors += 4;
      if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_txd: got %b, expected 1", uart_txd); end
      if (fifo_level !== '0) begin miscompares++; $display("[TB] FAIL mid_level: got %0d, expected 0", fifo_level); end
      if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b, expected 0", tx_busy); end
      if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_done: got %b, expected 0", tx_done); end
      bad = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         step_cycle();
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin miscompares++; $display("[TB] FAIL mid_no_frames: got %0d active cycles, expected 0", bad); end
   endtask

   task automatic test_random();
      int n, guard;
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) step_cycle();
         applyStimulus(8'($urandom), n);
      end
      guard = 0;
      while ((exp_q.size() != 0 || tx_busy) && guard < 20 * FRAME) begin
         step_cycle();
         guard++;
      end
      vectors += 3;
      if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL rand_drain: got %0d left, expected 0", exp_q.size()); end
      if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_busy: got %b, expected 0", tx_busy); end
      if (fifo_level !== '0) begin miscompares++; $display("[TB] FAIL rand_level: got %0d, expected 0", fifo_level); end
   endtask

   task automatic test_default_baud();
      int n, guard, s;
      int exp_edges[$];
      int got_edges[$];
      int done_cyc[$];
      logic pb, prevl;
      tx_data2 = 8'h0F;
      tx_valid2 = 1'b1;
      guard = 0;
      while (!tx_ready2 && guard < 100) begin step_cycle(); guard++; end
      step_cycle();
      n = cyc;
      tx_valid2 = 1'b0;
      s = n + 2;
      pb = 1'b1;
      for (int k = 0; k < NBITS; k++) begin
         if (frame_bit(8'h0F, k) != pb) exp_edges.push_back(s + k * BPS2);
         pb = frame_bit(8'h0F, k);
      end
      prevl = uart_txd2;
      for (int k = 0; k < FRAME2 + 10; k++) begin
         step_cycle();
         if (uart_txd2 !== prevl) got_edges.push_back(cyc);
         prevl = uart_txd2;
         if (tx_done2 === 1'b1) done_cyc.push_back(cyc);
      end
      vectors++;
      if (got_edges.size() != exp_edges.size()) begin
         miscompares++;
         $display("[TB] FAIL def_edge_count: got %0d, expected %0d", got_edges.size(), exp_edges.size());
      end else begin
         foreach (exp_edges[i]) begin
            vectors++;
            if (got_edges[i] != exp_edges[i]) begin
               miscompares++;
               $display("[TB] FAIL def_edge_%0d: got %0d, expected %0d", i, got_edges[i] - s, exp_edges[i] - s);
            end
         end
      end
      vectors += 2;
      if (done_cyc.size() != 1 || done_cyc[0] != n + FRAME2 + 1) begin
         miscompares++;
         $display("[TB] FAIL def_done: got %0d pulses, expected 1 at %0d", done_cyc.size(), FRAME2 + 1);
      end
      if (tx_busy2 !== 1'b0) begin miscompares++; $display("[TB] FAIL def_busy: got %b, expected 0", tx_busy2); end
   endtask

   initial begin
      sys_rst = 1'b1;
      tx_valid = 1'b0; tx_data = '0;
      tx_valid2 = 1'b0; tx_data2 = '0;
      test_reset();
      test_single();
      repeat (5) step_cycle();
`ifdef UART_TX_PARITY_EN
      test_parity();
      repeat (5) step_cycle();
`endif
      test_back_to_back();
      repeat (5) step_cycle();
      test_hold8();
      repeat (5) step_cycle();
      test_reset_mid();
      test_random();
      repeat (5) step_cycle();
      test_default_baud();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
